// File: rtl/ts_ci_tx_framer_if.sv
// rtl/ts_ci_tx_framer_if.sv - FIFO read side and CI bus input pins for the TS CI transmit framer
interface ts_ci_tx_framer_if;
  logic [8:0] fifo_q;
  logic       fifo_rdempty;
  logic [7:0] fifo_rdusedw;
  logic       fifo_rdreq;
  logic [7:0] ci_mdi;
  logic       ci_mistrt;
  logic       ci_mival;

  // Framer view: consumes the FIFO head, drives the CAM input pins
  modport master (
    input  fifo_q, fifo_rdempty, fifo_rdusedw,
    output fifo_rdreq, ci_mdi, ci_mistrt, ci_mival
  );

  // Environment view: FIFO read port and CAM receiver
  modport slave (
    output fifo_q, fifo_rdempty, fifo_rdusedw,
    input  fifo_rdreq, ci_mdi, ci_mistrt, ci_mival
  );
endinterface

// File: rtl/ts_ci_tx_framer.sv
// rtl/ts_ci_tx_framer.sv - packet-aligned CI transmit framer: whole TS packets only, idle gap between packets
module ts_ci_tx_framer #(
  parameter int         PKT_LEN    = 188,
  parameter int         GAP_CYCLES = 4,
  parameter logic [7:0] SYNC_BYTE  = 8'h47
) (
  input  logic               clk_9,
  input  logic               reset,
  input  logic               enable,
  ts_ci_tx_framer_if.master  bus,
  output logic [23:0]        pkts_sent,
  output logic [23:0]        pkts_err,
  output logic [23:0]        bytes_drop
);

  localparam int IDX_W = $clog2(PKT_LEN);
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HUNT = 2'd1;
  localparam logic [1:0] S_SEND = 2'd2;
  localparam logic [1:0] S_GAP  = 2'd3;

  // With no gap configured a finished packet returns straight to IDLE
  localparam logic [1:0] S_AFTER_PKT = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;

  logic [1:0]       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [23:0]      sent_q, sent_d;
  logic [23:0]      err_q, err_d;
  logic [23:0]      drop_q, drop_d;
  logic [7:0]       mdi_q;
  logic             mistrt_q;
  logic             mival_q;

  logic head_ok;
  logic pkt_ready;
  logic send_abort;
  logic send_pop;
  logic hunt_pop;
  logic last_byte;

  assign head_ok   = ~bus.fifo_rdempty & bus.fifo_q[8] & (bus.fifo_q[7:0] == SYNC_BYTE);
  assign pkt_ready = (32'(bus.fifo_rdusedw) >= PKT_LEN);
  assign last_byte = (32'(idx_q) == PKT_LEN - 1);

  // A start flag inside a packet means the previous packet was truncated; leave it at the head
  assign send_abort = (state_q == S_SEND) & (idx_q != '0) & bus.fifo_q[8];
  assign send_pop   = (state_q == S_SEND) & ~send_abort & ~bus.fifo_rdempty;
  assign hunt_pop   = (state_q == S_HUNT) & ~bus.fifo_rdempty & ~head_ok;

  assign bus.fifo_rdreq = send_pop | hunt_pop;
  assign bus.ci_mdi     = mdi_q;
  assign bus.ci_mistrt  = mistrt_q;
  assign bus.ci_mival   = mival_q;

  assign pkts_sent  = sent_q;
  assign pkts_err   = err_q;
  assign bytes_drop = drop_q;

  // Next-state: packet alignment, byte index, gap timing and traffic counters
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    gap_d   = gap_q;
    sent_d  = sent_q;
    err_d   = err_q;
    drop_d  = drop_q;
    case (state_q)
      S_IDLE: begin
        if (enable) begin
          if (~bus.fifo_rdempty & ~head_ok) begin
            state_d = S_HUNT;
          end else if (head_ok & pkt_ready) begin
            state_d = S_SEND;
            idx_d   = '0;
          end
        end
      end
      S_HUNT: begin
        if (hunt_pop) begin
          drop_d = drop_q + 24'd1;
        end else if (head_ok) begin
          state_d = S_IDLE;
        end
      end
      S_SEND: begin
        if (send_abort) begin
          err_d   = err_q + 24'd1;
          state_d = S_AFTER_PKT;
          idx_d   = '0;
          gap_d   = '0;
        end else if (send_pop) begin
          if (last_byte) begin
            sent_d  = sent_q + 24'd1;
            state_d = S_AFTER_PKT;
            idx_d   = '0;
            gap_d   = '0;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      S_GAP: begin
        if (32'(gap_q) + 32'd1 >= GAP_CYCLES) begin
          state_d = S_IDLE;
          gap_d   = '0;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, counters and registered CI pins; reset kills an in-flight packet immediately
  always_ff @(posedge clk_9 or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      gap_q    <= '0;
      sent_q   <= '0;
      err_q    <= '0;
      drop_q   <= '0;
      mdi_q    <= '0;
      mistrt_q <= 1'b0;
      mival_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      gap_q    <= gap_d;
      sent_q   <= sent_d;
      err_q    <= err_d;
      drop_q   <= drop_d;
      mival_q  <= send_pop;
      mistrt_q <= send_pop & (idx_q == '0);
      mdi_q    <= send_pop ? bus.fifo_q[7:0] : 8'h00;
    end
  end

endmodule

// File: tb/tb_ts_ci_tx_framer.sv
// tb/tb_ts_ci_tx_framer.sv - directed bench for ts_ci_tx_framer with a show-ahead FIFO model
module tb_ts_ci_tx_framer;
  localparam int PKT_LEN    = 188;
  localparam int GAP_CYCLES = 4;

  logic        clk_9;
  logic        reset;
  logic        enable;
  logic [23:0] pkts_sent;
  logic [23:0] pkts_err;
  logic [23:0] bytes_drop;

  ts_ci_tx_framer_if bus();

  ts_ci_tx_framer #(
    .PKT_LEN(PKT_LEN),
    .GAP_CYCLES(GAP_CYCLES),
    .SYNC_BYTE(8'h47)
  ) dut (
    .clk_9(clk_9),
    .reset(reset),
    .enable(enable),
    .bus(bus),
    .pkts_sent(pkts_sent),
    .pkts_err(pkts_err),
    .bytes_drop(bytes_drop)
  );

  initial clk_9 = 1'b0;
  always #5 clk_9 = ~clk_9;

  logic [8:0] fq[$];
  logic [7:0] obs_d[$];
  logic       obs_s[$];
  int         obs_t[$];
  int         n_chk = 0;
  int         n_fail = 0;
  int         cyc = 0;
  int         rdreq_hi = 0;
  int         rdreq_on_empty = 0;
  int         idle_noise = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive_fifo();
    bus.fifo_q       = (fq.size() != 0) ? fq[0] : 9'h000;
    bus.fifo_rdempty = (fq.size() == 0);
    bus.fifo_rdusedw = (fq.size() > 255) ? 8'hFF : 8'(fq.size());
  endtask

  task automatic push(input logic [8:0] w);
    fq.push_back(w);
    drive_fifo();
  endtask

  task automatic push_pkt();
    push({1'b1, 8'h47});
    for (int i = 1; i < PKT_LEN; i++) push({1'b0, 8'(i)});
  endtask

  function automatic logic [7:0] pkt_byte(input int i);
    return (i == 0) ? 8'h47 : 8'(i);
  endfunction

  task automatic clear_obs();
    obs_d.delete();
    obs_s.delete();
    obs_t.delete();
    rdreq_hi = 0;
  endtask

  task automatic tick();
    logic pop;
    #1;
    pop = bus.fifo_rdreq;
    if (pop) rdreq_hi++;
    if (pop && fq.size() == 0) rdreq_on_empty++;
    @(posedge clk_9);
    #1;
    cyc++;
    if (pop && fq.size() != 0) fq.delete(0);
    drive_fifo();
    if (bus.ci_mival) begin
      obs_d.push_back(bus.ci_mdi);
      obs_s.push_back(bus.ci_mistrt);
      obs_t.push_back(cyc);
    end else if (bus.ci_mistrt || bus.ci_mdi != 8'h00) begin
      idle_noise++;
    end
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic do_reset();
    enable = 1'b0;
    reset  = 1'b1;
    fq.delete();
    drive_fifo();
    run(2);
    reset = 1'b0;
    tick();
    clear_obs();
  endtask

  initial begin
    int starts;
    reset  = 1'b1;
    enable = 1'b0;
    drive_fifo();

    // Reset state
    do_reset();
    check_eq("rst_mival", bus.ci_mival, 1'b0);
    check_eq("rst_mistrt", bus.ci_mistrt, 1'b0);
    check_eq("rst_mdi", bus.ci_mdi, 8'h00);
    check_eq("rst_rdreq", bus.fifo_rdreq, 1'b0);
    check_eq("rst_sent", pkts_sent, 24'd0);
    check_eq("rst_err", pkts_err, 24'd0);
    check_eq("rst_drop", bytes_drop, 24'd0);

    // 1) One clean packet
    push_pkt();
    enable = 1'b1;
    run(200);
    check_eq("t1_count", obs_d.size(), PKT_LEN);
    starts = 0;
    foreach (obs_s[i]) if (obs_s[i]) starts++;
    check_eq("t1_starts", starts, 1);
    if (obs_d.size() == PKT_LEN) begin
      check_eq("t1_mistrt0", obs_s[0], 1'b1);
      for (int i = 0; i < PKT_LEN; i++) check_eq("t1_mdi", obs_d[i], pkt_byte(i));
      check_eq("t1_contig", obs_t[PKT_LEN-1] - obs_t[0], PKT_LEN - 1);
    end
    check_eq("t1_sent", pkts_sent, 24'd1);
    check_eq("t1_rdreq_after", bus.fifo_rdreq, 1'b0);

    // 2) Misaligned bytes ahead of a packet, including a start flag with a bad sync byte
    do_reset();
    push({1'b0, 8'h47});
    push({1'b0, 8'h12});
    push({1'b1, 8'h33});
    push_pkt();
    enable = 1'b1;
    run(220);
    check_eq("t2_drop", bytes_drop, 24'd3);
    check_eq("t2_sent", pkts_sent, 24'd1);
    check_eq("t2_count", obs_d.size(), PKT_LEN);
    if (obs_d.size() == PKT_LEN) begin
      check_eq("t2_first", obs_d[0], 8'h47);
      check_eq("t2_first_strt", obs_s[0], 1'b1);
      check_eq("t2_last", obs_d[PKT_LEN-1], 8'hBB);
    end

    // 3) Truncated packet of 100 bytes followed by a whole packet
    do_reset();
    push({1'b1, 8'h47});
    for (int i = 1; i < 100; i++) push({1'b0, 8'(i)});
    push_pkt();
    enable = 1'b1;
    run(420);
    check_eq("t3_err", pkts_err, 24'd1);
    check_eq("t3_sent", pkts_sent, 24'd1);
    check_eq("t3_drop", bytes_drop, 24'd0);
    check_eq("t3_count", obs_d.size(), 100 + PKT_LEN);
    if (obs_d.size() == 100 + PKT_LEN) begin
      check_eq("t3_trunc_contig", obs_t[99] - obs_t[0], 99);
      check_eq("t3_pkt2_strt", obs_s[100], 1'b1);
      check_eq("t3_pkt2_first", obs_d[100], 8'h47);
      check_eq("t3_pkt2_contig", obs_t[100+PKT_LEN-1] - obs_t[100], PKT_LEN - 1);
    end

    // 4) Two packets back-to-back in the FIFO: last MIVAL to next MISTRT is GAP_CYCLES+2 clocks
    do_reset();
    push_pkt();
    push_pkt();
    enable = 1'b1;
    run(450);
    check_eq("t4_sent", pkts_sent, 24'd2);
    check_eq("t4_count", obs_d.size(), 2 * PKT_LEN);
    if (obs_d.size() == 2 * PKT_LEN) begin
      check_eq("t4_gap", obs_t[PKT_LEN] - obs_t[PKT_LEN-1], GAP_CYCLES + 2);
      check_eq("t4_pkt2_strt", obs_s[PKT_LEN], 1'b1);
    end

    // 5) One word short of a packet: hold until the last word arrives
    do_reset();
    push({1'b1, 8'h47});
    for (int i = 1; i < PKT_LEN - 1; i++) push({1'b0, 8'(i)});
    enable = 1'b1;
    run(20);
    check_eq("t5_no_rdreq", rdreq_hi, 0);
    check_eq("t5_no_mival", obs_d.size(), 0);
    push({1'b0, 8'(PKT_LEN - 1)});
    tick();
    #1;
    check_eq("t5_start", bus.fifo_rdreq, 1'b1);
    run(200);
    check_eq("t5_sent", pkts_sent, 24'd1);
    check_eq("t5_count", obs_d.size(), PKT_LEN);

    // 6) Reset in the middle of a packet; the tail is hunted away afterwards
    do_reset();
    push_pkt();
    enable = 1'b1;
    for (int k = 0; k < 300 && obs_d.size() < 50; k++) tick();
    check_eq("t6_reached50", obs_d.size(), 50);
    reset = 1'b1;
    #1;
    check_eq("t6_mival_rst", bus.ci_mival, 1'b0);
    check_eq("t6_mistrt_rst", bus.ci_mistrt, 1'b0);
    check_eq("t6_rdreq_rst", bus.fifo_rdreq, 1'b0);
    check_eq("t6_sent_rst", pkts_sent, 24'd0);
    run(2);
    reset = 1'b0;
    run(300);
    check_eq("t6_drop", bytes_drop, 24'd138);
    check_eq("t6_sent", pkts_sent, 24'd0);
    check_eq("t6_count", obs_d.size(), 50);
    check_eq("t6_fifo_empty", fq.size(), 0);

    check_eq("rdreq_on_empty", rdreq_on_empty, 0);
    check_eq("idle_pins_zero", idle_noise, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
